spi_bus_arb: RTL and testbench

Arbitrates one physical FPGA-side SPI bus (SCLK, MOSI, MISO, N_SS slave selects) between two SPI masters: the lms_ctr CPU SPI port (master 0) and a hardware SPI engine (master 1).
- Each master requests ownership with a req/gnt handshake.
- Ownership always ends on a transaction boundary: all of the owner's slave selects are high.
- A watchdog revokes a stuck owner.
- A guard gap separates consecutive owners.

---
 rtl/spi_bus_arb.sv | 161 ++++++++++++++++
 tb/tb_spi_bus_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arb.sv
// Two-master SPI bus arbiter: round-robin grant on an idle bus, ownership ends only when
// all of the owner's selects are high, a watchdog revokes stuck owners, and a guard gap separates owners.
module spi_bus_arb #(
  parameter int N_SS        = 2,
  parameter int GUARD_CYC   = 4,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CPOL        = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m0_req,
  input  logic            m1_req,
  output logic            m0_gnt,
  output logic            m1_gnt,
  input  logic            m0_sclk,
  input  logic            m1_sclk,
  input  logic            m0_mosi,
  input  logic            m1_mosi,
  input  logic [N_SS-1:0] m0_ss_n,
  input  logic [N_SS-1:0] m1_ss_n,
  output logic            m0_miso,
  output logic            m1_miso,
  output logic            spi_sclk,
  output logic            spi_mosi,
  output logic [N_SS-1:0] spi_ss_n,
  input  logic            spi_miso,
  output logic            busy,
  output logic            timeout_pulse
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN0  = 2'd1;
  localparam logic [1:0] S_OWN1  = 2'd2;
  localparam logic [1:0] S_GUARD = 2'd3;

  localparam int         GW      = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [GW-1:0] L_GLAST = GW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [15:0]   L_TLAST = 16'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic          L_CPOL  = (CPOL != 0);
  localparam logic [1:0]    S_AFTER = (GUARD_CYC == 0) ? S_IDLE : S_GUARD;

  logic [1:0]      r_state;
  logic            r_last;
  logic            r_lock0;
  logic            r_lock1;
  logic [15:0]     r_tcnt;
  logic [GW-1:0]   r_gcnt;
  logic            r_gnt0;
  logic            r_gnt1;
  logic            r_sclk;
  logic            r_mosi;
  logic [N_SS-1:0] r_ssN;
  logic            r_timeout;

  logic            w_own1;
  logic            w_ownReq;
  logic            w_ownSclk;
  logic            w_ownMosi;
  logic [N_SS-1:0] w_ownSs;
  logic            w_elig0;
  logic            w_elig1;
  logic            w_release;
  logic            w_wdHit;
  logic [1:0]      w_stateNext;
  logic            w_mirror;
  logic            w_timeout;
  logic            w_setLock0;
  logic            w_setLock1;

  assign w_own1    = (r_state == S_OWN1);
  assign w_ownReq  = w_own1 ? m1_req  : m0_req;
  assign w_ownSclk = w_own1 ? m1_sclk : m0_sclk;
  assign w_ownMosi = w_own1 ? m1_mosi : m0_mosi;
  assign w_ownSs   = w_own1 ? m1_ss_n : m0_ss_n;
  assign w_elig0   = m0_req && !r_lock0;
  assign w_elig1   = m1_req && !r_lock1;
  assign w_release = !w_ownReq && (&w_ownSs);
  assign w_wdHit   = (TIMEOUT_CYC != 0) && (r_tcnt == L_TLAST);

  // A clean release always beats the watchdog when both land on the same edge.
  always_comb begin
    w_stateNext = r_state;
    w_mirror    = 1'b0;
    w_timeout   = 1'b0;
    w_setLock0  = 1'b0;
    w_setLock1  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig0 && (!w_elig1 || r_last)) w_stateNext = S_OWN0;
        else if (w_elig1)                    w_stateNext = S_OWN1;
      end
      S_OWN0, S_OWN1: begin
        if (w_release) begin
          w_stateNext = S_AFTER;
        end else if (w_wdHit) begin
          w_stateNext = S_AFTER;
          w_timeout   = 1'b1;
          w_setLock0  = !w_own1;
          w_setLock1  = w_own1;
        end else begin
          w_mirror = 1'b1;
        end
      end
      S_GUARD: begin
        if (r_gcnt == L_GLAST) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_lock0   <= 1'b0;
      r_lock1   <= 1'b0;
      r_tcnt    <= '0;
      r_gcnt    <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_sclk    <= L_CPOL;
      r_mosi    <= 1'b0;
      r_ssN     <= '1;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_timeout <= w_timeout;
      r_gnt0    <= (w_stateNext == S_OWN0);
      r_gnt1    <= (w_stateNext == S_OWN1);
      r_tcnt    <= (r_state == S_OWN0 || r_state == S_OWN1) ? r_tcnt + 16'd1 : '0;
      r_gcnt    <= (r_state == S_GUARD) ? r_gcnt + GW'(1) : '0;
      if (r_state == S_IDLE && w_stateNext == S_OWN0) r_last <= 1'b0;
      if (r_state == S_IDLE && w_stateNext == S_OWN1) r_last <= 1'b1;
      if (w_setLock0)   r_lock0 <= 1'b1;
      else if (!m0_req) r_lock0 <= 1'b0;
      if (w_setLock1)   r_lock1 <= 1'b1;
      else if (!m1_req) r_lock1 <= 1'b0;
      // The bus mirrors the owner only while it keeps ownership; every other edge parks it idle.
      if (w_mirror) begin
        r_sclk <= w_ownSclk;
        r_mosi <= w_ownMosi;
        r_ssN  <= w_ownSs;
      end else begin
        r_sclk <= L_CPOL;
        r_mosi <= 1'b0;
        r_ssN  <= '1;
      end
    end
  end

  assign m0_gnt        = r_gnt0;
  assign m1_gnt        = r_gnt1;
  assign spi_sclk      = r_sclk;
  assign spi_mosi      = r_mosi;
  assign spi_ss_n      = r_ssN;
  assign timeout_pulse = r_timeout;
  assign busy          = (r_state != S_IDLE);
  assign m0_miso       = (r_state == S_OWN0) && spi_miso;
  assign m1_miso       = (r_state == S_OWN1) && spi_miso;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Bench for spi_bus_arb: directed scenarios followed by random traffic, every cycle compared
// against an owner/guard-level reference model of the arbiter.
module tb_spi_bus_arb;
  localparam int NSS   = 2;
  localparam int GUARD = 4;
  localparam int TMO   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n = 1'b0;
  logic           m0_req = 1'b0, m1_req = 1'b0;
  logic           m0_gnt, m1_gnt;
  logic           m0_sclk = 1'b0, m1_sclk = 1'b0;
  logic           m0_mosi = 1'b0, m1_mosi = 1'b0;
  logic [NSS-1:0] m0_ss_n = '1, m1_ss_n = '1;
  logic           m0_miso, m1_miso;
  logic           spi_sclk, spi_mosi;
  logic [NSS-1:0] spi_ss_n;
  logic           spi_miso = 1'b0;
  logic           busy, timeout_pulse;

  spi_bus_arb #(.N_SS(NSS), .GUARD_CYC(GUARD), .TIMEOUT_CYC(TMO), .CPOL(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_sclk(m0_sclk), .m1_sclk(m1_sclk), .m0_mosi(m0_mosi), .m1_mosi(m1_mosi),
    .m0_ss_n(m0_ss_n), .m1_ss_n(m1_ss_n), .m0_miso(m0_miso), .m1_miso(m1_miso),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n), .spi_miso(spi_miso),
    .busy(busy), .timeout_pulse(timeout_pulse)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: who owns the bus, how many guard cycles remain, and what the bus should show.
  int       mOwner = -1;
  int       mGuardLeft = 0;
  int       mOwnCnt = 0;
  bit       mLast = 1'b1;
  bit       mLock [2];
  bit       mTo = 1'b0;
  bit [1:0] mSs = 2'b11;
  bit       mSclk = 1'b0;
  bit       mMosi = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelUpdate();
    bit       req [2];
    bit [1:0] ss [2];
    bit       sck [2];
    bit       mo [2];
    bit       setLock [2];
    bit       rel, e0, e1;
    int       x;
    req[0] = m0_req;  req[1] = m1_req;
    ss[0]  = m0_ss_n; ss[1]  = m1_ss_n;
    sck[0] = m0_sclk; sck[1] = m1_sclk;
    mo[0]  = m0_mosi; mo[1]  = m1_mosi;
    setLock[0] = 1'b0; setLock[1] = 1'b0;
    mTo = 1'b0; mSs = 2'b11; mSclk = 1'b0; mMosi = 1'b0;
    if (!reset_n) begin
      mOwner = -1; mGuardLeft = 0; mOwnCnt = 0; mLast = 1'b1;
      mLock[0] = 1'b0; mLock[1] = 1'b0;
      return;
    end
    if (mOwner >= 0) begin
      x   = mOwner;
      rel = !req[x] && (ss[x] == 2'b11);
      if (rel || mOwnCnt == TMO - 1) begin
        if (!rel) begin
          mTo = 1'b1;
          setLock[x] = 1'b1;
        end
        mOwner = -1;
        mGuardLeft = GUARD;
      end else begin
        mSs = ss[x]; mSclk = sck[x]; mMosi = mo[x];
        mOwnCnt++;
      end
    end else if (mGuardLeft > 0) begin
      mGuardLeft--;
    end else begin
      e0 = req[0] && !mLock[0];
      e1 = req[1] && !mLock[1];
      if (e0 || e1) begin
        if (e0 && e1) mOwner = mLast ? 0 : 1;
        else          mOwner = e0 ? 0 : 1;
        mLast = (mOwner == 1);
        mOwnCnt = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (setLock[i])   mLock[i] = 1'b1;
      else if (!req[i]) mLock[i] = 1'b0;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    spi_miso = 1'($urandom % 2);
    #1;
    checkOutput("m0_gnt", m0_gnt, mOwner == 0);
    checkOutput("m1_gnt", m1_gnt, mOwner == 1);
    checkOutput("spi_ss_n", spi_ss_n, mSs);
    checkOutput("spi_sclk", spi_sclk, mSclk);
    checkOutput("spi_mosi", spi_mosi, mMosi);
    checkOutput("busy", busy, (mOwner >= 0) || (mGuardLeft > 0));
    checkOutput("timeout_pulse", timeout_pulse, mTo);
    checkOutput("m0_miso", m0_miso, (mOwner == 0) && spi_miso);
    checkOutput("m1_miso", m1_miso, (mOwner == 1) && spi_miso);
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Random traffic: sticky requests and selects so transfers last long enough to matter.
  task automatic applyStimulus();
    if ($urandom % 8 == 0) m0_req = ~m0_req;
    if ($urandom % 8 == 0) m1_req = ~m1_req;
    if ($urandom % 12 == 0) m0_ss_n = ($urandom % 2) ? 2'b11 : 2'($urandom);
    if ($urandom % 12 == 0) m1_ss_n = ($urandom % 2) ? 2'b11 : 2'($urandom);
    m0_sclk = 1'($urandom); m1_sclk = 1'($urandom);
    m0_mosi = 1'($urandom); m1_mosi = 1'($urandom);
    reset_n = ($urandom % 400 != 0);
  endtask

  initial begin
    mLock[0] = 1'b0; mLock[1] = 1'b0;
    stepN(2);
    reset_n = 1'b1;
    stepCycle();

    // Tie after reset goes to m0, then m1, then back to m0.
    m0_req = 1'b1; m1_req = 1'b1;
    stepCycle();
    checkOutput("tieFirst", {m1_gnt, m0_gnt}, 2'b01);
    m0_ss_n = 2'b10;
    for (int i = 0; i < 16; i++) begin
      m0_sclk = i[0]; m0_mosi = 1'($urandom);
      stepCycle();
    end
    m0_ss_n = 2'b11; m0_req = 1'b0;
    stepCycle();
    checkOutput("releaseGnt", m0_gnt, 1'b0);
    stepN(GUARD);
    checkOutput("guardNoGnt", m1_gnt, 1'b0);
    stepCycle();
    checkOutput("tieSecond", m1_gnt, 1'b1);
    m1_ss_n = 2'b01;
    stepN(2);
    m1_req = 1'b0;
    stepN(3);
    checkOutput("deferHold", m1_gnt, 1'b1);
    m1_ss_n = 2'b11;
    stepCycle();
    checkOutput("deferRelease", m1_gnt, 1'b0);
    stepN(GUARD);
    m0_req = 1'b1; m1_req = 1'b1;
    stepCycle();
    checkOutput("tieThird", {m1_gnt, m0_gnt}, 2'b01);
    m0_req = 1'b0; m1_req = 1'b0;
    stepN(GUARD + 2);

    // Watchdog revoke at the 32nd owned edge, then lockout until req drops.
    m0_req = 1'b1;
    stepCycle();
    checkOutput("grantLatency", m0_gnt, 1'b1);
    m0_ss_n = 2'b10;
    stepN(TMO - 1);
    checkOutput("preTimeout", timeout_pulse, 1'b0);
    stepCycle();
    checkOutput("timeoutPulse", timeout_pulse, 1'b1);
    checkOutput("timeoutGnt", m0_gnt, 1'b0);
    checkOutput("timeoutSs", spi_ss_n, 2'b11);
    m0_ss_n = 2'b11;
    stepCycle();
    checkOutput("pulseWidth", timeout_pulse, 1'b0);
    stepN(10);
    checkOutput("lockHold", m0_gnt, 1'b0);
    m0_req = 1'b0;
    stepCycle();
    m0_req = 1'b1;
    stepCycle();
    checkOutput("regrant", m0_gnt, 1'b1);
    m0_req = 1'b0;
    stepN(GUARD + 2);

    // Release on the very edge the watchdog would fire: normal release, no lockout.
    m0_req = 1'b1;
    stepCycle();
    m0_ss_n = 2'b10;
    stepN(TMO - 1);
    m0_ss_n = 2'b11; m0_req = 1'b0;
    stepCycle();
    checkOutput("sameEdgePulse", timeout_pulse, 1'b0);
    checkOutput("sameEdgeGnt", m0_gnt, 1'b0);
    m0_req = 1'b1;
    stepN(GUARD);
    checkOutput("guardIgnoresReq", m0_gnt, 1'b0);
    stepCycle();
    checkOutput("noLockout", m0_gnt, 1'b1);
    m0_req = 1'b0;
    stepN(GUARD + 2);

    // Reset in the middle of an m1 transfer.
    m1_req = 1'b1;
    stepCycle();
    m1_ss_n = 2'b01;
    stepN(3);
    reset_n = 1'b0;
    stepCycle();
    checkOutput("rstGnt", m1_gnt, 1'b0);
    checkOutput("rstSs", spi_ss_n, 2'b11);
    checkOutput("rstBusy", busy, 1'b0);
    reset_n = 1'b1; m1_ss_n = 2'b11; m0_req = 1'b1;
    stepCycle();
    checkOutput("postResetTie", {m1_gnt, m0_gnt}, 2'b01);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
